// File: rtl/wb_load_unit.sv
// Writeback/load unit: routes execute results to the register file and waits
// on data memory for loads, extracting and extending the addressed lane.
module wb_load_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned RF_AW = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_reg_write,
  input  logic             i_mem_read,
  input  logic [1:0]       i_size,
  input  logic             i_unsigned,
  input  logic [XLEN-1:0]  i_ex_data,
  input  logic [RF_AW-1:0] i_rd,
  input  logic             i_dmem_rvalid,
  input  logic [XLEN-1:0]  i_dmem_rdata,
  output logic             o_rf_we,
  output logic [RF_AW-1:0] o_rf_waddr,
  output logic [XLEN-1:0]  o_rf_wdata,
  output logic             o_misaligned
);

  localparam int unsigned LANE_W = $clog2(XLEN / 8);
  localparam int unsigned SH_W   = LANE_W + 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } state_e;

  state_e             state_q, state_d;

  // Load context held across the memory wait
  logic               cap_we_q;
  logic [RF_AW-1:0]   cap_rd_q;
  logic [1:0]         cap_size_q;
  logic               cap_uns_q;
  logic [LANE_W-1:0]  cap_lane_q;
  logic               cap_load_c;

  logic               rf_we_d;
  logic               misaligned_d;
  logic [RF_AW-1:0]   rf_waddr_d;
  logic [XLEN-1:0]    rf_wdata_d;

  logic               accept_c;
  logic               bad_load_c;
  logic [SH_W-1:0]    shift_c;
  logic [7:0]         byte_c;
  logic [15:0]        half_c;
  logic [31:0]        word_c;
  logic [XLEN-1:0]    load_data_c;

  assign o_ready  = (state_q != WAIT_MEM);
  assign accept_c = i_valid && o_ready;

  // Alignment and size legality of the incoming load address
  always_comb begin
    bad_load_c = 1'b0;
    unique case (i_size)
      2'd0:    bad_load_c = 1'b0;
      2'd1:    bad_load_c = i_ex_data[0];
      2'd2:    bad_load_c = |i_ex_data[1:0];
      default: bad_load_c = (XLEN == 32) || (|i_ex_data[2:0]);
    endcase
  end

  // Lane extraction and extension of the memory response
  always_comb begin
    shift_c     = {cap_lane_q, 3'b000};
    byte_c      = 8'(i_dmem_rdata >> shift_c);
    half_c      = 16'(i_dmem_rdata >> shift_c);
    word_c      = 32'(i_dmem_rdata >> shift_c);
    load_data_c = i_dmem_rdata;
    unique case (cap_size_q)
      2'd0:    load_data_c = cap_uns_q ? XLEN'(byte_c) : XLEN'($signed(byte_c));
      2'd1:    load_data_c = cap_uns_q ? XLEN'(half_c) : XLEN'($signed(half_c));
      2'd2:    load_data_c = cap_uns_q ? XLEN'(word_c) : XLEN'($signed(word_c));
      default: load_data_c = i_dmem_rdata;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    rf_we_d      = 1'b0;
    misaligned_d = 1'b0;
    rf_waddr_d   = o_rf_waddr;
    rf_wdata_d   = o_rf_wdata;
    cap_load_c   = 1'b0;
    unique case (state_q)
      IDLE, WRITE: begin
        state_d = IDLE;
        if (accept_c) begin
          state_d = WRITE;
          if (i_mem_read) begin
            if (bad_load_c) begin
              misaligned_d = 1'b1;
            end else begin
              state_d    = WAIT_MEM;
              cap_load_c = 1'b1;
            end
          end else if (i_reg_write && (i_rd != '0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = i_rd;
            rf_wdata_d = i_ex_data;
          end
        end
      end
      WAIT_MEM: begin
        if (i_dmem_rvalid) begin
          state_d = WRITE;
          if (cap_we_q && (cap_rd_q != '0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = cap_rd_q;
            rf_wdata_d = load_data_c;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q      <= IDLE;
      o_rf_we      <= 1'b0;
      o_misaligned <= 1'b0;
      o_rf_waddr   <= '0;
      o_rf_wdata   <= '0;
    end else begin
      state_q      <= state_d;
      o_rf_we      <= rf_we_d;
      o_misaligned <= misaligned_d;
      o_rf_waddr   <= rf_waddr_d;
      o_rf_wdata   <= rf_wdata_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      cap_we_q   <= 1'b0;
      cap_rd_q   <= '0;
      cap_size_q <= '0;
      cap_uns_q  <= 1'b0;
      cap_lane_q <= '0;
    end else if (cap_load_c) begin
      cap_we_q   <= i_reg_write;
      cap_rd_q   <= i_rd;
      cap_size_q <= i_size;
      cap_uns_q  <= i_unsigned;
      cap_lane_q <= i_ex_data[LANE_W-1:0];
    end
  end

endmodule

// File: tb/tb_wb_load_unit.sv
// Drives a 32-bit and a 64-bit wb_load_unit with one shared stimulus stream and
// compares both against a transaction-level reference of load/writeback rules.
module tb_wb_load_unit;

  logic        clk = 1'b0;
  logic        rst_n, valid, reg_write, mem_read, uns, rvalid;
  logic [1:0]  size;
  logic [63:0] ex_data, rdata;
  logic [4:0]  rd;

  logic        rdy32, we32, mis32, rdy64, we64, mis64;
  logic [4:0]  waddr32, waddr64;
  logic [31:0] wdata32;
  logic [63:0] wdata64;

  int checks = 0;
  int errors = 0;

  // Reference state, index 0 = XLEN 32, index 1 = XLEN 64
  logic        pend [2];
  logic        c_we [2];
  logic [4:0]  c_rd [2];
  logic [1:0]  c_sz [2];
  logic        c_un [2];
  logic [63:0] c_ad [2];
  logic        e_we [2];
  logic        e_mis[2];
  logic [4:0]  e_wa [2];
  logic [63:0] e_wd [2];

  always #5 clk = ~clk;

  wb_load_unit #(.XLEN(32), .RF_AW(5)) dut32 (
    .i_clk(clk), .i_rst(rst_n), .i_valid(valid), .o_ready(rdy32),
    .i_reg_write(reg_write), .i_mem_read(mem_read), .i_size(size),
    .i_unsigned(uns), .i_ex_data(ex_data[31:0]), .i_rd(rd),
    .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata[31:0]),
    .o_rf_we(we32), .o_rf_waddr(waddr32), .o_rf_wdata(wdata32),
    .o_misaligned(mis32));

  wb_load_unit #(.XLEN(64), .RF_AW(5)) dut64 (
    .i_clk(clk), .i_rst(rst_n), .i_valid(valid), .o_ready(rdy64),
    .i_reg_write(reg_write), .i_mem_read(mem_read), .i_size(size),
    .i_unsigned(uns), .i_ex_data(ex_data), .i_rd(rd),
    .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata),
    .o_rf_we(we64), .o_rf_waddr(waddr64), .o_rf_wdata(wdata64),
    .o_misaligned(mis64));

  function automatic logic [63:0] xmask(int xlen, logic [63:0] v);
    return (xlen == 32) ? (v & 64'hFFFF_FFFF) : v;
  endfunction

  function automatic logic is_bad(int xlen, logic [1:0] sz, logic [63:0] addr);
    int nb = 1 << sz;
    return ((sz == 2'd3) && (xlen == 32)) || ((addr % nb) != 0);
  endfunction

  // Load value from the memory word by plain arithmetic on lanes and sign
  function automatic logic [63:0] load_result(int xlen, logic [1:0] sz, logic u,
                                               logic [63:0] addr, logic [63:0] rword);
    int          nbits = 8 << sz;
    int          lane  = int'(addr % (xlen / 8));
    logic [63:0] w     = xmask(xlen, rword);
    logic [63:0] raw;
    if (nbits == 64) return w;
    raw = (w >> (lane * 8)) & ((64'd1 << nbits) - 64'd1);
    if (!u && raw[nbits-1]) raw = raw - (64'd1 << nbits);
    return xmask(xlen, raw);
  endfunction

  task automatic model_step(input int m);
    int xlen = (m == 0) ? 32 : 64;
    e_we[m]  = 1'b0;
    e_mis[m] = 1'b0;
    if (!rst_n) begin
      pend[m] = 1'b0;
      e_wa[m] = '0;
      e_wd[m] = '0;
    end else if (pend[m]) begin
      if (rvalid) begin
        pend[m] = 1'b0;
        if (c_we[m] && c_rd[m] != 0) begin
          e_we[m] = 1'b1;
          e_wa[m] = c_rd[m];
          e_wd[m] = load_result(xlen, c_sz[m], c_un[m], c_ad[m], rdata);
        end
      end
    end else if (valid) begin
      if (mem_read) begin
        if (is_bad(xlen, size, ex_data)) e_mis[m] = 1'b1;
        else begin
          pend[m] = 1'b1;
          c_we[m] = reg_write; c_rd[m] = rd; c_sz[m] = size;
          c_un[m] = uns;       c_ad[m] = ex_data;
        end
      end else if (reg_write && rd != 0) begin
        e_we[m] = 1'b1;
        e_wa[m] = rd;
        e_wd[m] = xmask(xlen, ex_data);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
  endtask

  task automatic check_all();
    chk("ready32", 64'(rdy32), 64'(!pend[0]));
    chk("we32",    64'(we32),  64'(e_we[0]));
    chk("mis32",   64'(mis32), 64'(e_mis[0]));
    chk("waddr32", 64'(waddr32), 64'(e_wa[0]));
    chk("wdata32", 64'(wdata32), e_wd[0]);
    chk("ready64", 64'(rdy64), 64'(!pend[1]));
    chk("we64",    64'(we64),  64'(e_we[1]));
    chk("mis64",   64'(mis64), 64'(e_mis[1]));
    chk("waddr64", 64'(waddr64), 64'(e_wa[1]));
    chk("wdata64", wdata64, e_wd[1]);
  endtask

  task automatic step(input logic r, input logic v, input logic rw, input logic mr,
                      input logic [1:0] sz, input logic u, input logic [63:0] ex,
                      input logic [4:0] d, input logic rv, input logic [63:0] rw_data);
    rst_n = r; valid = v; reg_write = rw; mem_read = mr; size = sz; uns = u;
    ex_data = ex; rd = d; rvalid = rv; rdata = rw_data;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_all();
  endtask

  task automatic idle(input logic rv, input logic [63:0] rw_data);
    step(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 5'd0, rv, rw_data);
  endtask

  task automatic load(input logic [1:0] sz, input logic u, input logic [63:0] addr,
                      input logic [4:0] d, input logic rv);
    step(1'b1, 1'b1, 1'b1, 1'b1, sz, u, addr, d, rv, 64'hDEAD_BEEF_DEAD_BEEF);
  endtask

  task automatic alu(input logic [63:0] ex, input logic [4:0] d);
    step(1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, ex, d, 1'b0, 64'd0);
  endtask

  logic        r_rst, r_v, r_rw, r_mr, r_u, r_rv;
  logic [1:0]  r_sz;
  logic [63:0] r_ex, r_rdata;
  logic [4:0]  r_rd;

  initial begin
    for (int m = 0; m < 2; m++) begin
      pend[m] = 0; c_we[m] = 0; c_rd[m] = 0; c_sz[m] = 0; c_un[m] = 0; c_ad[m] = 0;
      e_we[m] = 0; e_mis[m] = 0; e_wa[m] = 0; e_wd[m] = 0;
    end

    // Reset
    step(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 64'h55, 5'd3, 1'b1, 64'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 5'd0, 1'b0, 64'd0);
    chk("rst_ready", 64'(rdy32), 64'd1);
    chk("rst_wdata", 64'(wdata32), 64'd0);

    // Non-load writes, back to back
    alu(64'h1234, 5'd5);
    chk("add_we", 64'(we32), 64'd1);
    chk("add_wdata", 64'(wdata32), 64'h1234);
    alu(64'hA, 5'd6);
    chk("b2b_waddr1", 64'(waddr32), 64'd6);
    alu(64'hB, 5'd7);
    chk("b2b_we2", 64'(we32), 64'd1);
    alu(64'hC, 5'd8);
    chk("b2b_wdata3", 64'(wdata32), 64'hC);
    idle(1'b0, 64'd0);
    chk("hold_wdata", 64'(wdata32), 64'hC);

    // LB / LBU at lane 3 with three stall cycles; rvalid on the accept edge is ignored
    load(2'd0, 1'b0, 64'h103, 5'd9, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0, 64'd0);
      chk("lb_stall_ready", 64'(rdy32), 64'd0);
    end
    idle(1'b1, 64'h0000_0000_80FF_0000);
    chk("lb_wdata", 64'(wdata32), 64'hFFFF_FF80);
    load(2'd0, 1'b1, 64'h103, 5'd9, 1'b0);
    idle(1'b1, 64'h0000_0000_80FF_0000);
    chk("lbu_wdata", 64'(wdata32), 64'h0000_0080);

    // LH / LHU at lane 2
    load(2'd1, 1'b0, 64'h102, 5'd10, 1'b0);
    idle(1'b1, 64'h0000_0000_8001_7FFF);
    chk("lh_wdata", 64'(wdata32), 64'hFFFF_8001);
    load(2'd1, 1'b1, 64'h102, 5'd10, 1'b0);
    idle(1'b1, 64'h0000_0000_8001_7FFF);
    chk("lhu_wdata", 64'(wdata32), 64'h0000_8001);

    // LW / LWU / LD on the 64-bit unit; LD is illegal on the 32-bit unit
    load(2'd2, 1'b0, 64'h104, 5'd11, 1'b0);
    idle(1'b1, 64'h8000_0001_0000_0000);
    chk("lw64_wdata", wdata64, 64'hFFFF_FFFF_8000_0001);
    load(2'd2, 1'b1, 64'h104, 5'd11, 1'b0);
    idle(1'b1, 64'h8000_0001_0000_0000);
    chk("lwu64_wdata", wdata64, 64'h0000_0000_8000_0001);
    load(2'd3, 1'b0, 64'h100, 5'd12, 1'b0);
    chk("ld32_mis", 64'(mis32), 64'd1);
    chk("ld32_we", 64'(we32), 64'd0);
    idle(1'b1, 64'h0123_4567_89AB_CDEF);
    chk("ld64_wdata", wdata64, 64'h0123_4567_89AB_CDEF);

    // Misaligned LW, then a write to x0
    load(2'd2, 1'b0, 64'h102, 5'd13, 1'b0);
    chk("lw_mis64", 64'(mis64), 64'd1);
    chk("lw_mis_ready", 64'(rdy64), 64'd1);
    alu(64'h77, 5'd0);
    chk("x0_we", 64'(we32), 64'd0);

    // Reset while waiting, then a stray response, then rvalid in idle
    load(2'd2, 1'b0, 64'h108, 5'd14, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 5'd0, 1'b0, 64'd0);
    chk("rst_wait_ready", 64'(rdy64), 64'd1);
    idle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("stray_we", 64'(we64), 64'd0);
    idle(1'b1, 64'h1111_2222_3333_4444);
    chk("idle_rvalid_we", 64'(we32), 64'd0);

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      r_rst   = ($urandom_range(0, 49) != 0);
      r_v     = $urandom_range(0, 1) != 0;
      r_rw    = $urandom_range(0, 3) != 0;
      r_mr    = $urandom_range(0, 1) != 0;
      r_sz    = 2'($urandom_range(0, 3));
      r_u     = $urandom_range(0, 1) != 0;
      r_ex    = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) r_ex = r_ex & ~((64'd1 << r_sz) - 64'd1);
      r_rd    = 5'($urandom_range(0, 31));
      r_rv    = $urandom_range(0, 2) == 0;
      r_rdata = {$urandom, $urandom};
      step(r_rst, r_v, r_rw, r_mr, r_sz, r_u, r_ex, r_rd, r_rv, r_rdata);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
